speed_test_axil_master: RTL and testbench
=========================================

# speed_test_axil_master

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command stream into register reads and writes on the speed-test controller's AXI-Lite slave port. It sits between the host-side command source (UART/JTAG bridge or test sequencer) and the controller, and returns one response per command. A per-transaction watchdog reports a hung slave instead of stalling the command source forever.

## Interface
- C_M_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 6: AXI address width; matches the controller's register space.
- TIMEOUT_CYCLES, 1024: watchdog limit per transaction, in cycles; must be ≥2.

- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address; bits [1:0] forced to 0 on the bus.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_data  out  32  read data; 0 for writes and timeouts.
- rsp_resp  out  2  BRESP/RRESP from the slave; 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by the watchdog.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. AWPROT = ARPROT = 3'b000. WSTRB = 4'hF.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE: cmd_ready = 1. On handshake, latch write, addr, and wdata; clear the watchdog; go to WRITE (write) or READ (read).
- WRITE: assert AWVALID and WVALID together. Each drops independently after its own handshake, tracked by aw_done and w_done. Same-cycle AW and W handshakes are legal. When both are done, go to WRESP.
- WRESP: BREADY = 1. On BVALID, capture BRESP, set rsp_data = 0, and go to RESP.
- READ: assert ARVALID until ARREADY, then go to RDATA.
- RDATA: RREADY = 1. On RVALID, capture RDATA and RRESP, and go to RESP.
- RESP: rsp_valid = 1, and the response fields stay stable until rsp_ready. Then return to IDLE. cmd_ready is 0 in every state except IDLE, so only one transaction is outstanding.
- Watchdog: a counter starts at 0 on command accept and increments every cycle in WRITE, WRESP, READ, and RDATA. When it reaches TIMEOUT_CYCLES-1 with no state-completing handshake that cycle, the transaction aborts:
  - all VALID/READY outputs are dropped next cycle;
  - the FSM goes to RESP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_data = 0.
  - A completing handshake on the limit cycle wins over the timeout.
- Late slave responses after an abort are ignored: BREADY and RREADY are low.
- Address and data outputs hold their latched values for the whole transaction.

## Timing
- Reset (async assert, sync release): state = IDLE, cmd_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_resp = 0, rsp_timeout = 0, all AXI VALID/READY = 0, AWADDR/ARADDR/WDATA = 0.
- rst_n asserted mid-transaction: all outputs go to reset values immediately, and the pending command is lost.
- Latency with a zero-wait slave (AWREADY/WREADY/ARREADY = 1, response one cycle later):
  - Command accept in cycle 0 → VALIDs high in cycle 1 → B/R handshake in cycle 2 → rsp_valid in cycle 3.
  - Back-to-back throughput is one command per 4 cycles when rsp_ready is held high.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Zero-wait write: cmd write addr 0x08, data 0xDEADBEEF → AWADDR = 0x08, WDATA = 0xDEADBEEF, WSTRB = 4'hF; rsp_valid 3 cycles after accept, rsp_resp = 0, rsp_timeout = 0.
- Skewed write channels: WREADY 5 cycles before AWREADY, then the reverse → WVALID drops right after its handshake and AWVALID is held; exactly one B handshake and one response each time.
- Read with backpressure: slave returns RDATA = 0x12345678 with RRESP = 2'b00 after 7 wait cycles, and rsp_ready is held low 4 cycles → rsp_data and rsp_resp stay stable until the consume; cmd_ready stays 0 until then.
- Timeout: TIMEOUT_CYCLES = 16, slave never raises ARREADY → ARVALID drops, and rsp_timeout = 1, rsp_resp = 2'b10, rsp_data = 0. An RVALID pulse afterwards is not acknowledged.
- Limit-cycle race: ARREADY arrives exactly on watchdog cycle 15 → the read completes normally with rsp_timeout = 0.
- Reset mid-write: drop rst_n while AWVALID = 1 → all VALIDs are 0 asynchronously; after release, cmd_ready = 1 and a new read completes normally.

Source files
------------

// File: rtl/speed_test_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command in, one response out.
// A per-transaction watchdog turns a hung slave into a SLVERR response with rsp_timeout set.
module speed_test_axil_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 6,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
   output logic [1:0]                      rsp_resp,
   output logic                            rsp_timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int DW   = C_M_AXI_DATA_WIDTH;
   localparam int AW   = C_M_AXI_ADDR_WIDTH;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LIMIT    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0]   ADDR_MASK   = ~AW'(3);
   localparam logic [1:0]      RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

   state_t          state_reg, state_next;
   logic            aw_done_reg, aw_done_next;
   logic            w_done_reg, w_done_next;
   logic [WD_W-1:0] wd_reg, wd_next;
   logic [AW-1:0]   addr_reg;
   logic [DW-1:0]   wdata_reg;
   logic            cmd_ready_reg;
   logic            awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;
   logic            rsp_valid_reg;
   logic [DW-1:0]   rsp_data_reg;
   logic [1:0]      rsp_resp_reg;
   logic            rsp_timeout_reg;

   logic            cmd_accept;
   logic            wd_limit_hit;
   logic            abort;
   logic            rsp_load;
   logic [DW-1:0]   rsp_data_in;
   logic [1:0]      rsp_resp_in;

   always_comb begin
      state_next   = state_reg;
      aw_done_next = aw_done_reg;
      w_done_next  = w_done_reg;
      // Saturates at the limit so a transaction that survives the limit cycle
      // can never wrap around and get a fresh budget.
      wd_next      = (wd_reg == WD_LIMIT) ? wd_reg : wd_reg + 1'b1;
      wd_limit_hit = (wd_reg == WD_LIMIT);
      cmd_accept   = 1'b0;
      abort        = 1'b0;
      rsp_load     = 1'b0;
      rsp_data_in  = '0;
      rsp_resp_in  = '0;

      case (state_reg)
         IDLE: begin
            wd_next = '0;
            if (cmd_valid) begin
               cmd_accept   = 1'b1;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               state_next   = cmd_write ? WRITE : READ;
            end
         end
         WRITE: begin
            aw_done_next = aw_done_reg | (awvalid_reg & M_AXI_AWREADY);
            w_done_next  = w_done_reg  | (wvalid_reg  & M_AXI_WREADY);
            if (aw_done_next && w_done_next) state_next = WRESP;
            else if (wd_limit_hit)           abort      = 1'b1;
         end
         WRESP: begin
            if (bready_reg && M_AXI_BVALID) begin
               state_next  = RESP;
               rsp_load    = 1'b1;
               rsp_resp_in = M_AXI_BRESP;
            end else if (wd_limit_hit) begin
               abort = 1'b1;
            end
         end
         READ: begin
            if (arvalid_reg && M_AXI_ARREADY) state_next = RDATA;
            else if (wd_limit_hit)            abort      = 1'b1;
         end
         RDATA: begin
            if (rready_reg && M_AXI_RVALID) begin
               state_next  = RESP;
               rsp_load    = 1'b1;
               rsp_data_in = M_AXI_RDATA;
               rsp_resp_in = M_AXI_RRESP;
            end else if (wd_limit_hit) begin
               abort = 1'b1;
            end
         end
         RESP: begin
            wd_next = wd_reg;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (abort) begin
         state_next  = RESP;
         rsp_load    = 1'b1;
         rsp_data_in = '0;
         rsp_resp_in = RESP_SLVERR;
      end
   end

   // Every handshake output is computed from the next state, so all ports come
   // straight from flops and nothing is combinational from an input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         aw_done_reg     <= 1'b0;
         w_done_reg      <= 1'b0;
         wd_reg          <= '0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         cmd_ready_reg   <= 1'b1;
         awvalid_reg     <= 1'b0;
         wvalid_reg      <= 1'b0;
         bready_reg      <= 1'b0;
         arvalid_reg     <= 1'b0;
         rready_reg      <= 1'b0;
         rsp_valid_reg   <= 1'b0;
         rsp_data_reg    <= '0;
         rsp_resp_reg    <= '0;
         rsp_timeout_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         aw_done_reg   <= aw_done_next;
         w_done_reg    <= w_done_next;
         wd_reg        <= wd_next;
         cmd_ready_reg <= (state_next == IDLE);
         awvalid_reg   <= (state_next == WRITE) && !aw_done_next;
         wvalid_reg    <= (state_next == WRITE) && !w_done_next;
         bready_reg    <= (state_next == WRESP);
         arvalid_reg   <= (state_next == READ);
         rready_reg    <= (state_next == RDATA);
         rsp_valid_reg <= (state_next == RESP);
         if (cmd_accept) begin
            addr_reg  <= cmd_addr & ADDR_MASK;
            wdata_reg <= cmd_wdata;
         end
         if (rsp_load) begin
            rsp_data_reg    <= rsp_data_in;
            rsp_resp_reg    <= rsp_resp_in;
            rsp_timeout_reg <= abort;
         end
      end
   end

   assign cmd_ready     = cmd_ready_reg;
   assign rsp_valid     = rsp_valid_reg;
   assign rsp_data      = rsp_data_reg;
   assign rsp_resp      = rsp_resp_reg;
   assign rsp_timeout   = rsp_timeout_reg;
   assign M_AXI_AWADDR  = addr_reg;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_reg;
   assign M_AXI_WDATA   = wdata_reg;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = wvalid_reg;
   assign M_AXI_BREADY  = bready_reg;
   assign M_AXI_ARADDR  = addr_reg;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_reg;
   assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_speed_test_axil_master.sv
// Randomized bench for speed_test_axil_master: a per-transaction slave with planned
// channel delays, checked against a timeline/memory model of the expected response.
module tb_speed_test_axil_master;

   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic [5:0]  M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;
   logic [31:0] model_mem [16];
   logic [31:0] slave_mem [16];

   speed_test_axil_master #(
      .C_M_AXI_DATA_WIDTH(32),
      .C_M_AXI_ADDR_WIDTH(6),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic slave_idle();
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
      M_AXI_BVALID  = 1'b0; M_AXI_BRESP  = 2'b00;
      M_AXI_RVALID  = 1'b0; M_AXI_RRESP  = 2'b00; M_AXI_RDATA = 32'h0;
   endtask

   // wr: d0 = AWREADY delay, d1 = WREADY delay, d2 = BVALID delay.
   // rd: d0 = ARREADY delay, d2 = RVALID delay.
   task automatic run_txn(input bit wr, input logic [5:0] addr, input logic [31:0] wdata,
                          input int d0, input int d1, input int d2, input int hold,
                          input logic [1:0] sresp);
      int          kmid, kf, tk, exp_lat, cyc, k, viol, hs_cnt, hold_bad;
      int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
      bit          exp_to, aw_got, w_got, b_done, ar_got, r_done;
      logic [31:0] exp_data, s_data;
      logic [1:0]  exp_resp;
      logic [5:0]  s_addr, exp_addr;
      logic [3:0]  idx;

      // Reference: transaction cycle k=0 is the first cycle after accept. The
      // watchdog tolerates cycles k >= TO-1 only if each one completes a phase.
      idx      = addr[5:2];
      exp_addr = {addr[5:2], 2'b00};
      kmid     = wr ? ((d0 > d1) ? d0 : d1) : d0;
      kf       = kmid + 1 + d2;
      exp_to   = 1'b0;
      tk       = 0;
      for (int kk = TO - 1; kk <= kf; kk++)
         if (!exp_to && kk != kmid && kk != kf) begin
            exp_to = 1'b1;
            tk     = kk;
         end
      exp_lat  = exp_to ? tk + 2 : kf + 2;
      exp_data = (exp_to || wr) ? 32'h0 : model_mem[idx];
      exp_resp = exp_to ? 2'b10 : sresp;
      if (wr && !exp_to) model_mem[idx] = wdata;

      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; b_done = 0; ar_got = 0; r_done = 0;
      viol = 0; hs_cnt = 0; s_addr = '0; s_data = '0;

      @(negedge clk);
      check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 60) begin
         k = cyc - 1;
         if (cmd_ready) viol++;
         if (wr) begin
            if ((aw_got && M_AXI_AWVALID) || (w_got && M_AXI_WVALID)) viol++;
            if (k <= TO - 1 && ((!aw_got && !M_AXI_AWVALID) || (!w_got && !M_AXI_WVALID))) viol++;
            if (aw_got && w_got && !b_done) begin
               M_AXI_BVALID = (b_wait >= d2);
               M_AXI_BRESP  = sresp;
               if (M_AXI_BVALID && M_AXI_BREADY) begin
                  b_done = 1'b1;
                  hs_cnt++;
                  slave_mem[s_addr[5:2]] = s_data;
               end else begin
                  b_wait++;
               end
            end else begin
               M_AXI_BVALID = 1'b0;
            end
            M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_wait >= d0);
            M_AXI_WREADY  = M_AXI_WVALID && !w_got && (w_wait >= d1);
            if (M_AXI_AWREADY) begin
               check_val("awaddr", 32'(M_AXI_AWADDR), 32'(exp_addr));
               check_val("awprot", 32'(M_AXI_AWPROT), 32'd0);
               s_addr = M_AXI_AWADDR;
               aw_got = 1'b1;
            end else if (M_AXI_AWVALID) aw_wait++;
            if (M_AXI_WREADY) begin
               check_val("wdata", M_AXI_WDATA, wdata);
               check_val("wstrb", 32'(M_AXI_WSTRB), 32'hF);
               s_data = M_AXI_WDATA;
               w_got  = 1'b1;
            end else if (M_AXI_WVALID) w_wait++;
         end else begin
            if (ar_got && M_AXI_ARVALID) viol++;
            if (k <= TO - 1 && !ar_got && !M_AXI_ARVALID) viol++;
            if (ar_got && !r_done) begin
               M_AXI_RVALID = (r_wait >= d2);
               M_AXI_RDATA  = slave_mem[s_addr[5:2]];
               M_AXI_RRESP  = sresp;
               if (M_AXI_RVALID && M_AXI_RREADY) begin
                  r_done = 1'b1;
                  hs_cnt++;
               end else begin
                  r_wait++;
               end
            end else begin
               M_AXI_RVALID = 1'b0;
            end
            M_AXI_ARREADY = M_AXI_ARVALID && !ar_got && (ar_wait >= d0);
            if (M_AXI_ARREADY) begin
               check_val("araddr", 32'(M_AXI_ARADDR), 32'(exp_addr));
               check_val("arprot", 32'(M_AXI_ARPROT), 32'd0);
               s_addr = M_AXI_ARADDR;
               ar_got = 1'b1;
            end else if (M_AXI_ARVALID) ar_wait++;
         end
         @(negedge clk);
         cyc++;
      end
      slave_idle();

      if (!rsp_valid) begin
         check_val("rsp_arrive", 32'(rsp_valid), 32'd1);
         return;
      end
      n_txn++;
      $display("txn %0d %s addr=0x%02h wdata=0x%08h -> data=0x%08h resp=%0d timeout=%0d latency=%0d",
               n_txn, wr ? "WR" : "RD", addr, wdata, rsp_data, rsp_resp, rsp_timeout, cyc);
      check_val("latency", 32'(cyc), 32'(exp_lat));
      check_val("rsp_data", rsp_data, exp_data);
      check_val("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
      check_val("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      check_val("protocol_viol", 32'(viol), 32'd0);
      check_val("resp_handshakes", 32'(hs_cnt), exp_to ? 32'd0 : 32'd1);
      check_val("quiet_in_resp",
                32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, cmd_ready}),
                32'd0);

      // Hold off the consumer while pulsing late slave responses; nothing may move.
      hold_bad = 0;
      for (int h = 0; h < hold; h++) begin
         M_AXI_BVALID = (h == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         M_AXI_RVALID = (h == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!rsp_valid || rsp_data !== exp_data || rsp_resp !== exp_resp ||
             rsp_timeout !== exp_to || cmd_ready || M_AXI_BREADY || M_AXI_RREADY ||
             M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID)
            hold_bad++;
      end
      if (hold > 0) check_val("hold_stable", 32'(hold_bad), 32'd0);
      slave_idle();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_val("rsp_consumed", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int d0, d1, d2;
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      slave_idle();
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 32'h0;
         slave_mem[i] = 32'h0;
      end

      repeat (3) @(negedge clk);
      check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check_val("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, 28'h0}, 32'h0);
      check_val("rst_rsp_data", rsp_data, 32'h0);
      check_val("rst_valids",
                32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
      check_val("rst_addr", 32'({M_AXI_AWADDR, M_AXI_ARADDR}), 32'd0);
      check_val("rst_wdata", M_AXI_WDATA, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_txn(1'b1, 6'h08, 32'hDEADBEEF, 0, 0, 0, 0, 2'b00);
      run_txn(1'b1, 6'h10, 32'hA5A5_0001, 6, 1, 0, 1, 2'b00);
      run_txn(1'b1, 6'h11, 32'h5A5A_0002, 1, 6, 2, 0, 2'b00);
      run_txn(1'b1, 6'h14, 32'h12345678, 0, 0, 0, 0, 2'b00);
      run_txn(1'b0, 6'h14, 32'h0, 0, 0, 7, 4, 2'b00);
      run_txn(1'b0, 6'h04, 32'h0, 99, 0, 0, 3, 2'b00);
      run_txn(1'b0, 6'h14, 32'h0, 15, 0, 0, 1, 2'b00);
      run_txn(1'b1, 6'h18, 32'hCAFE_F00D, 99, 2, 0, 2, 2'b00);

      for (int n = 0; n < 50; n++) begin
         d0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 18)) : int'($urandom_range(0, 4));
         d1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 18)) : int'($urandom_range(0, 4));
         d2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 18)) : int'($urandom_range(0, 4));
         run_txn(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
                 d0, d1, d2, int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      // Reset in the middle of a write: everything clears at once, write is lost.
      @(negedge clk);
      check_val("pre_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h20; cmd_wdata = 32'hBAD0_BAD0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("pre_rst_awvalid", 32'(M_AXI_AWVALID), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_valids",
                32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid}),
                32'd0);
      check_val("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check_val("async_rst_awaddr", 32'(M_AXI_AWADDR), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(1'b0, 6'h20, 32'h0, 1, 0, 2, 1, 2'b00);
      run_txn(1'b0, 6'h08, 32'h0, 0, 0, 0, 0, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
